// File: rtl/pcm_rx_deser.sv
// pcm_rx_deser: TDM serial PCM receiver. Frames the bit stream on fs,
// extracts the companded byte of one selected timeslot per frame and offers
// it with the A/u-law select on a valid/ready handshake. Flags frame-sync
// errors and overwritten (unconsumed) samples as one-cycle pulses.
module pcm_rx_deser #(
  parameter int NUM_SLOTS = 32,
  parameter int SLOT_W    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_en,
  input  logic              fs,
  input  logic              sdin,
  input  logic [SLOT_W-1:0] slot_sel,
  input  logic              law_in,
  input  logic              s_ready,
  output logic [7:0]        s,
  output logic              law,
  output logic              s_valid,
  output logic              overrun,
  output logic              frame_err,
  input  logic              scan_in0,
  input  logic              scan_in1,
  input  logic              scan_in2,
  input  logic              scan_in3,
  input  logic              scan_in4,
  input  logic              scan_enable,
  input  logic              test_mode,
  output logic              scan_out0,
  output logic              scan_out1,
  output logic              scan_out2,
  output logic              scan_out3,
  output logic              scan_out4
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            r_state;
  logic [2:0]        r_bit_cnt;
  logic [SLOT_W-1:0] r_slot_cnt;
  logic [SLOT_W-1:0] r_sel;
  logic [7:0]        r_shreg;
  logic [7:0]        r_s;
  logic              r_law;
  logic              r_s_valid;
  logic              r_overrun;
  logic              r_frame_err;

  logic              w_frame_start;
  logic [SLOT_W-1:0] w_sel;
  logic              w_hit;
  logic              w_sync;
  logic              w_lost_sync;
  logic              w_unused_dft;

  // Counters back at slot 0 bit 0: only reachable in RUN by wrapping the frame.
  assign w_frame_start = (r_bit_cnt == 3'd0) && (r_slot_cnt == '0);
  // Selection is re-sampled at bit 0 of every slot, so bit 0 compares live.
  assign w_sel         = (r_bit_cnt == 3'd0) ? slot_sel : r_sel;
  assign w_hit         = (r_slot_cnt == w_sel);
  // fs outside slot 0 bit 0 (or any fs while hunting) (re)aligns the frame.
  assign w_sync        = bit_en && fs && ((r_state == HUNT) || !w_frame_start);
  assign w_lost_sync   = bit_en && !fs && (r_state == RUN) && w_frame_start;

  // DFT hooks are stitched at scan insertion; functionally inert here.
  assign w_unused_dft = &{1'b0, scan_in0, scan_in1, scan_in2, scan_in3,
                          scan_in4, scan_enable, test_mode};
  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

  assign s         = r_s;
  assign law       = r_law;
  assign s_valid   = r_s_valid;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

  // Framing FSM, slot/bit counters, shift register and output handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= HUNT;
      r_bit_cnt   <= '0;
      r_slot_cnt  <= '0;
      r_sel       <= '0;
      r_shreg     <= '0;
      r_s         <= '0;
      r_law       <= 1'b0;
      r_s_valid   <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      if (r_s_valid && s_ready) begin
        r_s_valid <= 1'b0;
      end
      if (w_sync) begin
        // Entry bit is bit 0 of slot 0; any partial byte is dropped. Shifting
        // sdin unconditionally is safe: a load needs 7 more shifts in-slot.
        r_state     <= RUN;
        r_frame_err <= (r_state == RUN);
        r_bit_cnt   <= 3'd1;
        r_slot_cnt  <= '0;
        r_sel       <= slot_sel;
        r_shreg     <= {7'b0, sdin};
      end else if (w_lost_sync) begin
        r_state     <= HUNT;
        r_frame_err <= 1'b1;
        r_bit_cnt   <= '0;
        r_slot_cnt  <= '0;
      end else if (bit_en && (r_state == RUN)) begin
        if (r_bit_cnt == 3'd0) begin
          r_sel <= slot_sel;
        end
        if (w_hit) begin
          r_shreg <= {r_shreg[6:0], sdin};
          if (r_bit_cnt == 3'd7) begin
            r_s       <= {r_shreg[6:0], sdin};
            r_law     <= law_in;
            r_s_valid <= 1'b1;
            r_overrun <= r_s_valid && !s_ready;
          end
        end
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_slot_cnt <= (r_slot_cnt == LAST_SLOT) ? '0 : r_slot_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pcm_rx_deser.sv
// Testbench for pcm_rx_deser (8-slot build): directed frames with
// hand-computed bytes; expected samples queued, monitor pops on transfer.
module tb_pcm_rx_deser;

  localparam int NS = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          bit_en, fs, sdin, law_in, s_ready;
  logic [SW-1:0] slot_sel;
  logic [7:0]    s;
  logic          law, s_valid, overrun, frame_err;
  logic          scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         fe_cnt   = 0;
  int         ov_cnt   = 0;
  logic [8:0] exp_q[$];
  logic [7:0] vb;

  always #5 clk = ~clk;

  pcm_rx_deser #(.NUM_SLOTS(NS), .SLOT_W(SW)) u_dut (
    .clk(clk), .reset(rst_n), .bit_en(bit_en), .fs(fs), .sdin(sdin),
    .slot_sel(slot_sel), .law_in(law_in), .s_ready(s_ready),
    .s(s), .law(law), .s_valid(s_valid), .overrun(overrun), .frame_err(frame_err),
    .scan_in0(1'b0), .scan_in1(1'b0), .scan_in2(1'b0), .scan_in3(1'b0),
    .scan_in4(1'b0), .scan_enable(1'b0), .test_mode(1'b0),
    .scan_out0(scan_out0), .scan_out1(scan_out1), .scan_out2(scan_out2),
    .scan_out3(scan_out3), .scan_out4(scan_out4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pulse counters and scoreboard pop on every handshake transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (overrun)   ov_cnt++;
      if (frame_err) fe_cnt++;
      if (s_valid && s_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_sample: got %0h expected none", {law, s});
        end else begin
          check("sample", 32'({law, s}), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic f, input logic d);
    bit_en = 1'b1; fs = f; sdin = d;
    tick();
    bit_en = 1'b0; fs = 1'b0; sdin = 1'b0;
  endtask

  task automatic send_slot(input logic f, input logic [7:0] b, input logic rdy7);
    for (int i = 0; i < 8; i++) begin
      if (i == 7 && rdy7) s_ready = 1'b1;
      send_bit(f && (i == 0), b[7-i]);
    end
  endtask

  task automatic send_zero_slots(input int n);
    for (int k = 0; k < n; k++) send_slot(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; bit_en = 1'b0; fs = 1'b0; sdin = 1'b0;
    slot_sel = '0; law_in = 1'b0; s_ready = 1'b0;
    tick(); tick();
    check("rst_s", 32'(s), 0);
    check("rst_valid", 32'(s_valid), 0);
    check("rst_law_pulses", 32'({law, overrun, frame_err}), 0);
    check("rst_scan", 32'({scan_out0, scan_out1, scan_out2, scan_out3, scan_out4}), 0);
    rst_n = 1'b1;
    tick();

    // Basic extraction of slot 3 (D5, A-law) and consumption.
    slot_sel = 3'd3; law_in = 1'b0;
    send_slot(1'b1, 8'h00, 1'b0); send_zero_slots(2);
    check("t1_pre_valid", 32'(s_valid), 0);
    send_slot(1'b0, 8'hD5, 1'b0);
    check("t1_valid", 32'(s_valid), 1);
    check("t1_s", 32'(s), 32'h00D5);
    check("t1_law", 32'(law), 0);
    exp_q.push_back({1'b0, 8'hD5});
    s_ready = 1'b1;
    tick();
    check("t1_consumed", 32'(s_valid), 0);
    s_ready = 1'b0;
    send_zero_slots(4);

    // Overrun on back-to-back unconsumed loads; none when ready on load cycle.
    send_slot(1'b1, 8'h00, 1'b0); send_zero_slots(2); send_slot(1'b0, 8'h3C, 1'b0); send_zero_slots(4);
    check("t2_first_valid", 32'(s_valid), 1);
    send_slot(1'b1, 8'h00, 1'b0); send_zero_slots(2); send_slot(1'b0, 8'hA7, 1'b0);
    check("t2_overrun", 32'(overrun), 1);
    check("t2_s_overwritten", 32'(s), 32'h00A7);
    exp_q.push_back({1'b0, 8'hA7});
    send_zero_slots(4);
    check("t2_ov_count", 32'(ov_cnt), 1);
    send_slot(1'b1, 8'h00, 1'b0); send_zero_slots(2);
    exp_q.push_back({1'b0, 8'h5E});
    send_slot(1'b0, 8'h5E, 1'b1);
    check("t2_no_overrun", 32'(overrun), 0);
    check("t2_valid_kept", 32'(s_valid), 1);
    check("t2_s_new", 32'(s), 32'h005E);
    tick();
    s_ready = 1'b0;
    send_zero_slots(4);
    check("t2_ov_final", 32'(ov_cnt), 1);
    check("t2_no_frame_err", 32'(fe_cnt), 0);
    check("t2_drained", 32'(exp_q.size()), 0);

    // Misplaced fs at slot 5 bit 2 resyncs; then a missing fs drops to hunt.
    slot_sel = 3'd0; s_ready = 1'b1;
    exp_q.push_back({1'b0, 8'h11});
    send_slot(1'b1, 8'h11, 1'b0); send_zero_slots(4);
    send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b0);
    exp_q.push_back({1'b0, 8'h2A});
    vb = 8'h2A;
    send_bit(1'b1, vb[7]);
    check("t3_frame_err", 32'(frame_err), 1);
    for (int i = 1; i < 8; i++) send_bit(1'b0, vb[7-i]);
    check("t3_fe_count", 32'(fe_cnt), 1);
    send_zero_slots(7);
    s_ready = 1'b0;
    tick();
    check("t3_drained", 32'(exp_q.size()), 0);
    send_bit(1'b0, 1'b0);
    check("t4_frame_err", 32'(frame_err), 1);
    for (int i = 0; i < 63; i++) send_bit(1'b0, 1'b1);
    check("t4_hunt_no_valid", 32'(s_valid), 0);
    check("t4_fe_count", 32'(fe_cnt), 2);

    // Mid-slot selection change 3->7, u-law.
    slot_sel = 3'd3; law_in = 1'b1; s_ready = 1'b1;
    send_slot(1'b1, 8'h00, 1'b0); send_zero_slots(2);
    exp_q.push_back({1'b1, 8'h96});
    vb = 8'h96;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) slot_sel = 3'd7;
      send_bit(1'b0, vb[7-i]);
    end
    exp_q.push_back({1'b1, 8'h4B});
    send_zero_slots(3); send_slot(1'b0, 8'h4B, 1'b0);
    tick();
    check("t5_drained", 32'(exp_q.size()), 0);

    // Asynchronous reset mid-shift with a pending sample.
    slot_sel = 3'd2; law_in = 1'b0; s_ready = 1'b0;
    send_slot(1'b1, 8'h00, 1'b0); send_slot(1'b0, 8'h00, 1'b0); send_slot(1'b0, 8'hE1, 1'b0);
    check("t6_pending_valid", 32'(s_valid), 1);
    check("t6_pending_s", 32'(s), 32'h00E1);
    send_zero_slots(5);
    send_slot(1'b1, 8'h00, 1'b0); send_slot(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_async_reset", 32'({s, law, s_valid, overrun, frame_err}), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 60; i++) send_bit(1'b0, 1'b1);
    check("t6_no_valid_without_fs", 32'(s_valid), 0);
    s_ready = 1'b1;
    send_slot(1'b1, 8'h00, 1'b0); send_slot(1'b0, 8'h00, 1'b0);
    exp_q.push_back({1'b0, 8'h69});
    send_slot(1'b0, 8'h69, 1'b0);
    send_zero_slots(5);
    tick(); tick();
    check("final_queue_empty", 32'(exp_q.size()), 0);
    check("final_fe_count", 32'(fe_cnt), 2);
    check("final_ov_count", 32'(ov_cnt), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
